// File: rtl/pipeline_catch_fifo_if.sv
// pipeline_catch_fifo_if: stream signals between the delay line, the catch FIFO and its consumer
interface pipeline_catch_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  last_in;
    logic                  stall_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  last_out;
    logic                  ready_in;

    modport master (
        output data_in, valid_in, last_in, ready_in,
        input  stall_out, data_out, valid_out, last_out
    );

    modport slave (
        input  data_in, valid_in, last_in, ready_in,
        output stall_out, data_out, valid_out, last_out
    );
endinterface

// File: rtl/pipeline_catch_fifo.sv
// pipeline_catch_fifo: elastic buffer catching a non-stallable delay line; PIPELINE_CATCH_FIFO_LAST_EN stores end-of-packet flags
module pipeline_catch_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     clear_in,
    pipeline_catch_fifo_if.slave     bus,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out
);
    localparam int AW = $clog2(DEPTH);
`ifdef PIPELINE_CATCH_FIFO_LAST_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   STALL_AT = (AW+1)'(DEPTH - LATENCY);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          valid, push, pop;
    logic [EW-1:0] wr_entry, head;

    assign valid = count_q != '0;
    assign pop   = valid & bus.ready_in;
    // a full buffer still accepts a word when the head leaves in the same cycle
    assign push  = bus.valid_in & ((count_q < FULL) | pop);
    assign head  = mem_q[rd_ptr_q];
`ifdef PIPELINE_CATCH_FIFO_LAST_EN
    assign wr_entry     = {bus.last_in, bus.data_in};
    assign bus.last_out = valid & head[DATA_WIDTH];
`else
    assign wr_entry     = bus.data_in;
    assign bus.last_out = 1'b0;
`endif
    assign bus.valid_out = valid;
    assign bus.data_out  = valid ? head[DATA_WIDTH-1:0] : '0;
    // threshold on the registered count only, so upstream sees no combinational loop
    assign bus.stall_out = count_q >= STALL_AT;
    assign count_out     = count_q;
    assign overflow_out  = overflow_q;

    // next-state: clear discards the cycle's push/pop, otherwise advance pointers and count
    always_comb begin
        wr_ptr_d   = clear_in ? '0 : (push ? wr_ptr_q + PTR_ONE : wr_ptr_q);
        rd_ptr_d   = clear_in ? '0 : (pop ? rd_ptr_q + PTR_ONE : rd_ptr_q);
        count_d    = clear_in ? '0 : count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
        overflow_d = clear_in ? 1'b0 : overflow_q | (bus.valid_in & ~push);
    end

    // control state register with asynchronous reset
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // storage write; contents need no reset since count gates every read
    always_ff @(posedge clk_in) begin
        if (push && !clear_in) mem_q[wr_ptr_q] <= wr_entry;
    end
endmodule

// File: tb/tb_pipeline_catch_fifo.sv
// tb_pipeline_catch_fifo: directed self-checking bench for pipeline_catch_fifo (DEPTH 16, LATENCY 4)
module tb_pipeline_catch_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] count;
    logic       ovf;
    int         n_cmp = 0;
    int         n_err = 0;
`ifdef PIPELINE_CATCH_FIFO_LAST_EN
    localparam logic LAST_EXP = 1'b1;
`else
    localparam logic LAST_EXP = 1'b0;
`endif

    pipeline_catch_fifo_if #(.DATA_WIDTH(8)) bus ();

    pipeline_catch_fifo #(.DATA_WIDTH(8), .DEPTH(16), .LATENCY(4)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .clear_in(clear),
        .bus(bus),
        .count_out(count),
        .overflow_out(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        bus.last_in  = 1'b0;
        bus.ready_in = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        step();
        step();
        n_cmp++; if (bus.valid_out !== 1'b0 || count !== 5'd0 || ovf !== 1'b0 || bus.stall_out !== 1'b0) begin
            n_err++; $display("FAIL reset_init: valid=%b count=%0d ovf=%b stall=%b want 0 0 0 0", bus.valid_out, count, ovf, bus.stall_out);
        end
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'h60 + 8'(i);
            step();
        end
        bus.valid_in = 1'b0;
        n_cmp++; if (count !== 5'd5 || bus.valid_out !== 1'b1 || bus.data_out !== 8'h60) begin
            n_err++; $display("FAIL reset_fill: count=%0d valid=%b data=%h want 5 1 60", count, bus.valid_out, bus.data_out);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.valid_out !== 1'b0 || count !== 5'd0 || ovf !== 1'b0 || bus.stall_out !== 1'b0 || bus.data_out !== 8'h00) begin
            n_err++; $display("FAIL reset_async: valid=%b count=%0d ovf=%b stall=%b data=%h want all 0", bus.valid_out, count, ovf, bus.stall_out, bus.data_out);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_latency();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        idle();
        bus.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = words[i];
            step();
            n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== words[i] || count !== 5'd1) begin
                n_err++; $display("FAIL latency_%0d: valid=%b data=%h count=%0d want 1 %h 1", i, bus.valid_out, bus.data_out, count, words[i]);
            end
        end
        bus.valid_in = 1'b0;
        step();
        n_cmp++; if (bus.valid_out !== 1'b0 || count !== 5'd0 || bus.data_out !== 8'h00) begin
            n_err++; $display("FAIL latency_drain: valid=%b count=%0d data=%h want 0 0 00", bus.valid_out, count, bus.data_out);
        end
    endtask

    task automatic test_stall();
        idle();
        for (int i = 1; i <= 16; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'h40 + 8'(i - 1);
            step();
            n_cmp++; if (bus.stall_out !== (i >= 12) || count !== 5'(i)) begin
                n_err++; $display("FAIL stall_%0d: stall=%b count=%0d want %b %0d", i, bus.stall_out, count, i >= 12, i);
            end
        end
        bus.valid_in = 1'b0;
        n_cmp++; if (ovf !== 1'b0 || bus.data_out !== 8'h40) begin
            n_err++; $display("FAIL stall_full: ovf=%b head=%h want 0 40", ovf, bus.data_out);
        end
    endtask

    task automatic test_overflow();
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hAA;
        bus.ready_in = 1'b0;
        step();
        n_cmp++; if (ovf !== 1'b1 || count !== 5'd16 || bus.data_out !== 8'h40) begin
            n_err++; $display("FAIL ovf_drop: ovf=%b count=%0d head=%h want 1 16 40", ovf, count, bus.data_out);
        end
        bus.data_in  = 8'hBB;
        bus.ready_in = 1'b1;
        step();
        n_cmp++; if (count !== 5'd16 || bus.data_out !== 8'h41 || ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_simul: count=%0d head=%h ovf=%b want 16 41 1", count, bus.data_out, ovf);
        end
        bus.valid_in = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            step();
            n_cmp++; if (bus.data_out !== (j == 15 ? 8'hBB : 8'h41 + 8'(j)) || count !== 5'(16 - j)) begin
                n_err++; $display("FAIL ovf_pop_%0d: head=%h count=%0d want %h %0d", j, bus.data_out, count, j == 15 ? 8'hBB : 8'h41 + 8'(j), 16 - j);
            end
        end
        step();
        n_cmp++; if (bus.valid_out !== 1'b0 || count !== 5'd0 || ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_empty: valid=%b count=%0d ovf=%b want 0 0 1", bus.valid_out, count, ovf);
        end
        bus.ready_in = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: ovf=%b want 0", ovf);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q [$];
        int sent = 0;
        int got = 0;
        idle();
        for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
            bus.ready_in = (cyc % 3) != 0;
            bus.valid_in = (sent < 40) && !bus.stall_out;
            bus.data_in  = 8'h80 + 8'(sent);
            if (bus.valid_out && bus.ready_in) begin
                n_cmp++; if (exp_q.size() == 0 || bus.data_out !== exp_q[0]) begin
                    n_err++; $display("FAIL wrap_%0d: data=%h want %h", got, bus.data_out, exp_q.size() ? exp_q[0] : 8'hxx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (bus.valid_in) begin
                exp_q.push_back(bus.data_in);
                sent++;
            end
            step();
        end
        idle();
        n_cmp++; if (got != 40 || count !== 5'd0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL wrap_end: got=%0d count=%0d ovf=%b want 40 0 0", got, count, ovf);
        end
    endtask

    task automatic test_last();
        idle();
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h01;
        step();
        n_cmp++; if (bus.data_out !== 8'h01 || bus.last_out !== 1'b0) begin
            n_err++; $display("FAIL last_first: data=%h last=%b want 01 0", bus.data_out, bus.last_out);
        end
        bus.data_in = 8'h02;
        bus.last_in = 1'b1;
        step();
        idle();
        n_cmp++; if (bus.data_out !== 8'h01 || bus.last_out !== 1'b0 || count !== 5'd2) begin
            n_err++; $display("FAIL last_hold: data=%h last=%b count=%0d want 01 0 2", bus.data_out, bus.last_out, count);
        end
        bus.ready_in = 1'b1;
        step();
        n_cmp++; if (bus.data_out !== 8'h02 || bus.last_out !== LAST_EXP) begin
            n_err++; $display("FAIL last_flag: data=%h last=%b want 02 %b", bus.data_out, bus.last_out, LAST_EXP);
        end
        step();
        n_cmp++; if (bus.valid_out !== 1'b0 || bus.last_out !== 1'b0) begin
            n_err++; $display("FAIL last_empty: valid=%b last=%b want 0 0", bus.valid_out, bus.last_out);
        end
    endtask

    task automatic test_clear();
        idle();
        for (int i = 0; i < 7; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'hC0 + 8'(i);
            step();
        end
        n_cmp++; if (count !== 5'd7) begin
            n_err++; $display("FAIL clear_fill: count=%0d want 7", count);
        end
        clear        = 1'b1;
        bus.ready_in = 1'b1;
        step();
        idle();
        n_cmp++; if (count !== 5'd0 || bus.valid_out !== 1'b0 || bus.data_out !== 8'h00 || bus.stall_out !== 1'b0) begin
            n_err++; $display("FAIL clear_flush: count=%0d valid=%b data=%h stall=%b want 0 0 00 0", count, bus.valid_out, bus.data_out, bus.stall_out);
        end
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hD5;
        step();
        idle();
        n_cmp++; if (bus.data_out !== 8'hD5 || count !== 5'd1) begin
            n_err++; $display("FAIL clear_restart: data=%h count=%0d want d5 1", bus.data_out, count);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_overflow();
        test_wrap();
        test_last();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_catch_fifo.md
# pipeline_catch_fifo

Elastic buffer that sits directly downstream of the fixed-latency `pipeline` delay line in the UDP datapath and absorbs its output. The delay line cannot be stalled mid-flight, so this block raises `stall_out` early enough that every in-flight word still lands in free storage. It presents a valid/ready stream to the next consumer (packet parser / MAC TX side), with optional end-of-packet marking.

## Interface
- `DATA_WIDTH`, default 8: width of one data word.
- `DEPTH`, default 16: storage entries; power of two, ≥ 4.
- `LATENCY`, default 4: words that can still arrive after `stall_out` rises (upstream pipeline `STAGES` plus source delay); must be < `DEPTH`.

Ports:
- `clk_in`  in  1: single clock; all logic on its rising edge.
- `rst_n_in`  in  1: reset, asynchronous, active-low.
- `clear_in`  in  1: synchronous flush.
- `data_in`  in  DATA_WIDTH: word from the delay line.
- `valid_in`  in  1: `data_in` carries a word this cycle.
- `last_in`  in  1: word is the last of a packet.
- `stall_out`  out  1: upstream must stop issuing new words.
- `data_out`  out  DATA_WIDTH: head word.
- `valid_out`  out  1: head word present.
- `last_out`  out  1: head word is end of packet.
- `ready_in`  in  1: consumer accepts head word.
- `count_out`  out  $clog2(DEPTH)+1: words stored.
- `overflow_out`  out  1: sticky; a word was dropped.

## Operation
- Circular buffer: `wr_ptr`, `rd_ptr` of $clog2(DEPTH) bits wrapping DEPTH-1 → 0; `count` register of $clog2(DEPTH)+1 bits.
- Push = `valid_in` and (`count` < DEPTH or pop). Pop = `valid_out` and `ready_in`.
- Full with simultaneous valid_in and pop: both happen, count stays DEPTH.
- Full, valid_in, no pop: word dropped, pointers/count unchanged, `overflow_out` set.
- Empty: `valid_out` = 0; `ready_in` ignored; no pop.
- `count` next = count + push − pop.
- `valid_out` = (count ≠ 0); `data_out`/`last_out` = entry at `rd_ptr`, forced to 0 when `valid_out` = 0.
- `stall_out` = (DEPTH − count) ≤ LATENCY, combinational from the `count` register only.
- `clear_in`: next cycle pointers, count, `overflow_out` = 0; push/pop that cycle discarded. Priority: reset > clear > push/pop.
- Reset (any time, including mid-packet): pointers, count 0; `valid_out`, `data_out`, `last_out`, `overflow_out` 0; `stall_out` = 0 (given LATENCY < DEPTH); storage contents need not be reset.

## Timing
- Write-to-read latency 1 cycle: word pushed at edge N is on `data_out` with `valid_out` = 1 after edge N when buffer was empty.
- No combinational path from `valid_in`, `data_in` or `ready_in` to any output.
- `stall_out` rises the cycle after the push that brings count to DEPTH − LATENCY; with upstream obeying it, at most LATENCY further words arrive, so no overflow in compliant use.
- `overflow_out` rises the cycle after the dropped word; holds until reset or clear.
- Sustained throughput 1 word/cycle with `ready_in` = 1.

## Configuration
- `PIPELINE_CATCH_FIFO_LAST_EN` defined: each entry stores DATA_WIDTH+1 bits; `last_out` follows the stored `last_in`.
- Not defined: storage DATA_WIDTH bits; `last_in` ignored; `last_out` tied to 0. Ports present in both builds.

## Test plan
- Reset: assert `rst_n_in` = 0 asynchronously mid-stream with count = 5 → immediately `valid_out` = 0, `count_out` = 0, `overflow_out` = 0, `stall_out` = 0.
- Latency/order: push 0x11, 0x22, 0x33 on consecutive cycles, `ready_in` = 1 → `data_out` 0x11, 0x22, 0x33 on the three cycles after each push, count never exceeds 1.
- Stall threshold (DEPTH 16, LATENCY 4), `ready_in` = 0: push 12 words → `stall_out` = 1 after 12th, not before; push 4 more → count 16, `overflow_out` = 0.
- Overflow/simultaneous: at count 16, push 0xAA with `ready_in` = 0 → dropped, `overflow_out` = 1, count 16; then push 0xBB with `ready_in` = 1 → count stays 16, 0xBB read out last after 15 more pops.
- Wrap: 40 words through with random `ready_in` → output equals input sequence exactly, pointers wrap twice.
- Last flag (macro on): push 0x01, 0x02 with `last_in` = 1 on 0x02 → `last_out` = 1 only with 0x02; macro off → `last_out` always 0. `clear_in` at count 7 → count 0, `valid_out` 0 next cycle.
